mcpu_seq_ctrl: RTL and testbench

//  Parametrised multicycle control sequencer for the mcpu datapath. Generates bus-enable/load

---
 rtl/mcpu_seq_ctrl_if.sv | 46 ++++
 rtl/mcpu_seq_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_mcpu_seq_ctrl.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/mcpu_seq_ctrl_if.sv
// Signal bundle between the mcpu control sequencer (master) and the datapath/memory (slave).
// Carries opcode/flag inputs, the memory handshake, bus-driver and load strobes, and status.
interface mcpu_seq_ctrl_if #(
    parameter int unsigned RET_W = 32
);
    logic             run;
    logic [7:0]       opc;
    logic [1:0]       flg;
    logic             mem_rdy;
    logic             mem_req;
    logic             a2abus;
    logic             b2abus;
    logic             pc2abus;
    logic             a2dbus;
    logic             b2dbus;
    logic             pc2dbus;
    logic             ram2dbus;
    logic             dec2dbus;
    logic             loadreg;
    logic             loadflag;
    logic             dbus2pc;
    logic             dbus2ram;
    logic             dbus2opc;
    logic             dbus2opl;
    logic [1:0]       pcinc;
    logic [1:0]       wr;
    logic [2:0]       state;
    logic             err;
    logic [RET_W-1:0] retired;

    modport master (
        input  run, opc, flg, mem_rdy,
        output mem_req, a2abus, b2abus, pc2abus,
        output a2dbus, b2dbus, pc2dbus, ram2dbus, dec2dbus,
        output loadreg, loadflag, dbus2pc, dbus2ram, dbus2opc, dbus2opl,
        output pcinc, wr, state, err, retired
    );

    modport slave (
        output run, opc, flg, mem_rdy,
        input  mem_req, a2abus, b2abus, pc2abus,
        input  a2dbus, b2dbus, pc2dbus, ram2dbus, dec2dbus,
        input  loadreg, loadflag, dbus2pc, dbus2ram, dbus2opc, dbus2opl,
        input  pcinc, wr, state, err, retired
    );
endinterface

// File: rtl/mcpu_seq_ctrl.sv
// Multicycle FETCH-OPERAND-EXECUTE control sequencer for the mcpu datapath, with memory
// wait states, a bounded-wait error trap, run-edge restart from HALT and a retire counter.
module mcpu_seq_ctrl #(
    parameter int unsigned WAIT_MAX = 15,
    parameter int unsigned WCNT_W   = 4,
    parameter int unsigned RET_W    = 32,
    parameter logic [4:0]  CMP_CODE = 5'h04
) (
    input  logic            clk,
    input  logic            rst,
    mcpu_seq_ctrl_if.master bus
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_OPCFT = 3'd1;
    localparam logic [2:0] S_OPLFT = 3'd2;
    localparam logic [2:0] S_EXE   = 3'd3;
    localparam logic [2:0] S_HALT  = 3'd4;
    localparam logic [2:0] S_ERR   = 3'd5;

    localparam logic [WCNT_W-1:0] WAIT_LIM = WCNT_W'(WAIT_MAX);

    logic [2:0]       state_r;
    logic             err_r;
    logic [RET_W-1:0] retired_r;
    logic [WCNT_W-1:0] wcnt_r;
    logic             run_q_r;

    logic [2:0] nxt_s;
    logic       done_s;
    logic       mem_req_s;
    logic       a2abus_s, b2abus_s, pc2abus_s;
    logic       a2dbus_s, b2dbus_s, ram2dbus_s, dec2dbus_s;
    logic       loadreg_s, loadflag_s, dbus2pc_s, dbus2ram_s, dbus2opc_s, dbus2opl_s;
    logic [1:0] pcinc_s;
    logic [1:0] wr_s;
    logic       is_load_s;
    logic       is_store_s;
    logic       wait_s;
    logic       timeout_s;

    assign is_load_s  = (bus.opc == 8'h08);
    assign is_store_s = (bus.opc == 8'h0C) || (bus.opc == 8'h0D) || (bus.opc == 8'h0E);

    // Strobe decode and next-state selection from state, opcode, flags and mem_rdy
    always_comb begin
        nxt_s      = state_r;
        done_s     = 1'b0;
        mem_req_s  = 1'b0;
        a2abus_s   = 1'b0;
        b2abus_s   = 1'b0;
        pc2abus_s  = 1'b0;
        a2dbus_s   = 1'b0;
        b2dbus_s   = 1'b0;
        ram2dbus_s = 1'b0;
        dec2dbus_s = 1'b0;
        loadreg_s  = 1'b0;
        loadflag_s = 1'b0;
        dbus2pc_s  = 1'b0;
        dbus2ram_s = 1'b0;
        dbus2opc_s = 1'b0;
        dbus2opl_s = 1'b0;
        pcinc_s    = 2'd0;
        wr_s       = 2'd0;
        case (state_r)
            S_IDLE: begin
                if (bus.run) begin
                    nxt_s = S_OPCFT;
                end else begin
                    nxt_s = S_IDLE;
                end
            end
            S_OPCFT: begin
                mem_req_s  = 1'b1;
                pc2abus_s  = 1'b1;
                ram2dbus_s = 1'b1;
                if (bus.mem_rdy) begin
                    dbus2opc_s = 1'b1;
                    pcinc_s    = 2'd1;
                    nxt_s      = S_OPLFT;
                end else begin
                    nxt_s = S_OPCFT;
                end
            end
            S_OPLFT: begin
                mem_req_s  = 1'b1;
                pc2abus_s  = 1'b1;
                ram2dbus_s = 1'b1;
                if (bus.mem_rdy) begin
                    dbus2opl_s = 1'b1;
                    pcinc_s    = bus.opc[0] ? 2'd2 : (bus.opc[1] ? 2'd3 : 2'd1);
                    nxt_s      = S_EXE;
                end else begin
                    nxt_s = S_OPLFT;
                end
            end
            S_EXE: begin
                loadflag_s = 1'b1;
                if (bus.opc[7]) begin
                    // ALU op: compare updates flags only, bit 0 picks the immediate source
                    pcinc_s    = 2'd1;
                    loadreg_s  = (bus.opc[6:2] != CMP_CODE);
                    dec2dbus_s = bus.opc[0];
                    a2dbus_s   = ~bus.opc[0];
                    done_s     = 1'b1;
                end else begin
                    case (bus.opc)
                        8'h00: done_s = 1'b1;
                        8'h01: begin
                            dec2dbus_s = 1'b1;
                            dbus2pc_s  = 1'b1;
                            done_s     = 1'b1;
                        end
                        8'h03, 8'h05: begin
                            dec2dbus_s = (bus.opc == 8'h03) ? bus.flg[0] : ~bus.flg[0];
                            dbus2pc_s  = (bus.opc == 8'h03) ? bus.flg[0] : ~bus.flg[0];
                            done_s     = 1'b1;
                        end
                        8'h04: begin
                            a2dbus_s  = 1'b1;
                            loadreg_s = 1'b1;
                            pcinc_s   = 2'd1;
                            done_s    = 1'b1;
                        end
                        8'h06: begin
                            b2dbus_s  = 1'b1;
                            dbus2pc_s = 1'b1;
                            done_s    = 1'b1;
                        end
                        8'h08: begin
                            mem_req_s  = 1'b1;
                            a2abus_s   = 1'b1;
                            ram2dbus_s = 1'b1;
                            loadreg_s  = bus.mem_rdy;
                            pcinc_s    = bus.mem_rdy ? 2'd1 : 2'd0;
                            done_s     = bus.mem_rdy;
                        end
                        8'h0C, 8'h0D, 8'h0E: begin
                            mem_req_s  = 1'b1;
                            b2abus_s   = 1'b1;
                            a2dbus_s   = 1'b1;
                            dbus2ram_s = bus.mem_rdy;
                            pcinc_s    = bus.mem_rdy ? 2'd1 : 2'd0;
                            if (!bus.mem_rdy) begin
                                wr_s = 2'd0;
                            end else if (bus.opc == 8'h0C) begin
                                wr_s = 2'd3;
                            end else if (bus.opc == 8'h0D) begin
                                wr_s = 2'd2;
                            end else begin
                                wr_s = 2'd1;
                            end
                            done_s = bus.mem_rdy;
                        end
                        default: done_s = 1'b1;
                    endcase
                end
                if (done_s) begin
                    nxt_s = (bus.opc == 8'h00) ? S_HALT : S_OPCFT;
                end else begin
                    nxt_s = S_EXE;
                end
            end
            S_HALT: begin
                if (bus.run && !run_q_r) begin
                    nxt_s = S_OPCFT;
                end else begin
                    nxt_s = S_HALT;
                end
            end
            S_ERR:   nxt_s = S_ERR;
            default: nxt_s = S_IDLE;
        endcase
    end

    // A memory access that reaches the wait limit with mem_rdy still low traps to ERR
    assign wait_s    = mem_req_s & ~bus.mem_rdy;
    assign timeout_s = wait_s && (wcnt_r == WAIT_LIM);

    // State, wait counter, run history, sticky error and retired-instruction counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= S_IDLE;
            err_r     <= 1'b0;
            retired_r <= '0;
            wcnt_r    <= '0;
            run_q_r   <= 1'b0;
        end else begin
            state_r <= timeout_s ? S_ERR : nxt_s;
            err_r   <= err_r | timeout_s;
            run_q_r <= bus.run;
            wcnt_r  <= wait_s ? (wcnt_r + WCNT_W'(1)) : '0;
            if (done_s) begin
                retired_r <= retired_r + RET_W'(1);
            end else begin
                retired_r <= retired_r;
            end
        end
    end

    assign bus.mem_req  = mem_req_s;
    assign bus.a2abus   = a2abus_s;
    assign bus.b2abus   = b2abus_s;
    assign bus.pc2abus  = pc2abus_s;
    assign bus.a2dbus   = a2dbus_s;
    assign bus.b2dbus   = b2dbus_s;
    assign bus.pc2dbus  = 1'b0;
    assign bus.ram2dbus = ram2dbus_s;
    assign bus.dec2dbus = dec2dbus_s;
    assign bus.loadreg  = loadreg_s;
    assign bus.loadflag = loadflag_s;
    assign bus.dbus2pc  = dbus2pc_s;
    assign bus.dbus2ram = dbus2ram_s;
    assign bus.dbus2opc = dbus2opc_s;
    assign bus.dbus2opl = dbus2opl_s;
    assign bus.pcinc    = pcinc_s;
    assign bus.wr       = wr_s;
    assign bus.state    = state_r;
    assign bus.err      = err_r;
    assign bus.retired  = retired_r;
endmodule

// File: tb/tb_mcpu_seq_ctrl.sv
// Scoreboard bench for mcpu_seq_ctrl: the driver queues hand-computed per-cycle expectations,
// a negedge monitor pops and compares them and checks bus-driver exclusivity every cycle.
module tb_mcpu_seq_ctrl;
    localparam logic [14:0] MREQ  = 15'h4000;
    localparam logic [14:0] A2A   = 15'h2000;
    localparam logic [14:0] B2A   = 15'h1000;
    localparam logic [14:0] PC2A  = 15'h0800;
    localparam logic [14:0] A2D   = 15'h0400;
    localparam logic [14:0] B2D   = 15'h0200;
    localparam logic [14:0] PC2D  = 15'h0100;
    localparam logic [14:0] R2D   = 15'h0080;
    localparam logic [14:0] DEC2D = 15'h0040;
    localparam logic [14:0] LREG  = 15'h0020;
    localparam logic [14:0] LFLG  = 15'h0010;
    localparam logic [14:0] D2PC  = 15'h0008;
    localparam logic [14:0] D2RAM = 15'h0004;
    localparam logic [14:0] D2OPC = 15'h0002;
    localparam logic [14:0] D2OPL = 15'h0001;
    localparam logic [14:0] ALL   = 15'h7FFF;
    localparam logic [14:0] NONE  = 15'h0000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mcpu_seq_ctrl_if #(.RET_W(32)) bif ();

    mcpu_seq_ctrl #(
        .WAIT_MAX(15),
        .WCNT_W  (4),
        .RET_W   (32),
        .CMP_CODE(5'h04)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bif)
    );

    typedef struct {
        string       nm;
        logic [2:0]  st;
        logic [14:0] sb;
        logic [14:0] msk;
        logic [1:0]  pi;
        logic [1:0]  wr;
        logic        err;
        logic [31:0] ret;
    } exp_t;

    exp_t        expq[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] ret_m  = 32'd0;
    logic [14:0] act_sb;

    assign act_sb = {bif.mem_req, bif.a2abus, bif.b2abus, bif.pc2abus,
                     bif.a2dbus, bif.b2dbus, bif.pc2dbus, bif.ram2dbus, bif.dec2dbus,
                     bif.loadreg, bif.loadflag, bif.dbus2pc, bif.dbus2ram, bif.dbus2opc, bif.dbus2opl};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_c(input string nm, input logic [2:0] st, input logic [14:0] sb,
                            input logic [14:0] msk, input logic [1:0] pi, input logic [1:0] w,
                            input logic e);
        exp_t x;
        x.nm  = nm;
        x.st  = st;
        x.sb  = sb;
        x.msk = msk;
        x.pi  = pi;
        x.wr  = w;
        x.err = e;
        x.ret = ret_m;
        expq.push_back(x);
    endtask

    // OPCFT then OPLFT with memory ready at once; opl_pi is the hand-decoded operand increment
    task automatic fetch(input logic [7:0] op, input logic [1:0] opl_pi);
        bif.opc     = op;
        bif.mem_rdy = 1'b1;
        expect_c("opcft", 3'd1, MREQ | PC2A | R2D | D2OPC, ALL, 2'd1, 2'd0, 1'b0);
        tick();
        expect_c("oplft", 3'd2, MREQ | PC2A | R2D | D2OPL, ALL, opl_pi, 2'd0, 1'b0);
        tick();
    endtask

    task automatic exec(input string nm, input logic [14:0] sb, input logic [1:0] pi,
                        input logic [1:0] w);
        expect_c(nm, 3'd3, sb, ALL, pi, w, 1'b0);
        tick();
        ret_m = ret_m + 32'd1;
    endtask

    // Monitor: bus exclusivity every cycle, and scoreboard comparison when an expectation is queued
    always @(negedge clk) begin
        exp_t e;
        checks = checks + 1;
        assert ($onehot0({bif.a2abus, bif.b2abus, bif.pc2abus}) &&
                $onehot0({bif.a2dbus, bif.b2dbus, bif.pc2dbus, bif.ram2dbus, bif.dec2dbus}))
        else begin
            errors = errors + 1;
            $display("FAIL bus_onehot: got sb=%h, required at most one abus and one dbus driver", act_sb);
        end
        if (expq.size() > 0) begin
            e = expq.pop_front();
            checks = checks + 1;
            if (bif.state !== e.st || (act_sb & e.msk) !== (e.sb & e.msk) || bif.pcinc !== e.pi ||
                bif.wr !== e.wr || bif.err !== e.err || bif.retired !== e.ret) begin
                errors = errors + 1;
                $display("FAIL %s: got state=%0d sb=%h pcinc=%0d wr=%0d err=%0b retired=%0d, required state=%0d sb=%h pcinc=%0d wr=%0d err=%0b retired=%0d (mask %h)",
                         e.nm, bif.state, act_sb, bif.pcinc, bif.wr, bif.err, bif.retired,
                         e.st, e.sb, e.pi, e.wr, e.err, e.ret, e.msk);
            end
        end
    end

    initial begin
        rst         = 1'b1;
        bif.run     = 1'b0;
        bif.opc     = 8'h00;
        bif.flg     = 2'b00;
        bif.mem_rdy = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        expect_c("reset", 3'd0, NONE, ALL, 2'd0, 2'd0, 1'b0);
        tick();

        // ALU with immediate operand: 1,2,3 then back to 1 with one retired
        bif.run     = 1'b1;
        bif.mem_rdy = 1'b1;
        bif.opc     = 8'h81;
        expect_c("idle_run", 3'd0, NONE, ALL, 2'd0, 2'd0, 1'b0);
        tick();
        fetch(8'h81, 2'd2);
        exec("alu_exe", LFLG | LREG | DEC2D, 2'd1, 2'd0);

        // Load with three wait cycles in EXE
        fetch(8'h08, 2'd1);
        bif.mem_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            expect_c("load_wait", 3'd3, MREQ | A2A | R2D, ALL & ~LFLG, 2'd0, 2'd0, 1'b0);
            tick();
        end
        bif.mem_rdy = 1'b1;
        exec("load_done", MREQ | A2A | R2D | LREG | LFLG, 2'd1, 2'd0);

        bif.flg = 2'b00;
        fetch(8'h03, 2'd2);
        exec("je_not_taken", LFLG, 2'd0, 2'd0);
        bif.flg = 2'b01;
        fetch(8'h03, 2'd2);
        exec("je_taken", LFLG | DEC2D | D2PC, 2'd0, 2'd0);
        fetch(8'h05, 2'd2);
        exec("jnz_not_taken", LFLG, 2'd0, 2'd0);
        fetch(8'h90, 2'd1);
        exec("cmp", LFLG | A2D, 2'd1, 2'd0);
        fetch(8'h04, 2'd1);
        exec("mov", LFLG | A2D | LREG, 2'd1, 2'd0);
        fetch(8'h0D, 2'd2);
        exec("store4", MREQ | B2A | A2D | D2RAM | LFLG, 2'd1, 2'd2);
        fetch(8'h06, 2'd3);
        exec("jmpr", LFLG | B2D | D2PC, 2'd0, 2'd0);
        fetch(8'h0C, 2'd1);
        exec("store8", MREQ | B2A | A2D | D2RAM | LFLG, 2'd1, 2'd3);
        fetch(8'h00, 2'd1);
        exec("hlt", LFLG, 2'd0, 2'd0);

        // HALT: run held high does not restart, a fresh rising edge does
        expect_c("halt_run_held", 3'd4, NONE, ALL, 2'd0, 2'd0, 1'b0);
        tick();
        expect_c("halt_run_held2", 3'd4, NONE, ALL, 2'd0, 2'd0, 1'b0);
        tick();
        bif.run = 1'b0;
        expect_c("halt_run_low", 3'd4, NONE, ALL, 2'd0, 2'd0, 1'b0);
        tick();
        bif.run = 1'b1;
        expect_c("halt_run_edge", 3'd4, NONE, ALL, 2'd0, 2'd0, 1'b0);
        tick();

        // Restart, then reset while in OPLFT
        bif.opc = 8'h81;
        expect_c("restart_opcft", 3'd1, MREQ | PC2A | R2D | D2OPC, ALL, 2'd1, 2'd0, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        rst     = 1'b0;
        bif.run = 1'b0;
        ret_m   = 32'd0;
        expect_c("rst_in_oplft", 3'd0, NONE, ALL, 2'd0, 2'd0, 1'b0);
        tick();

        // Timeout: sixteen OPCFT cycles without ready
        bif.run     = 1'b1;
        bif.mem_rdy = 1'b0;
        expect_c("idle_to", 3'd0, NONE, ALL, 2'd0, 2'd0, 1'b0);
        tick();
        expect_c("opcft_wait", 3'd1, MREQ | PC2A | R2D, ALL, 2'd0, 2'd0, 1'b0);
        tick();
        repeat (15) tick();
        bif.mem_rdy = 1'b1;
        expect_c("timeout_err", 3'd5, NONE, ALL, 2'd0, 2'd0, 1'b1);
        tick();
        expect_c("err_sticky", 3'd5, NONE, ALL, 2'd0, 2'd0, 1'b1);
        tick();

        // Ready arriving on the sixteenth wait cycle beats the timeout
        rst = 1'b1;
        tick();
        rst         = 1'b0;
        bif.mem_rdy = 1'b0;
        expect_c("idle_after_err", 3'd0, NONE, ALL, 2'd0, 2'd0, 1'b0);
        tick();
        repeat (15) tick();
        bif.mem_rdy = 1'b1;
        expect_c("rdy_at_limit", 3'd1, MREQ | PC2A | R2D | D2OPC, ALL, 2'd1, 2'd0, 1'b0);
        tick();
        expect_c("no_err", 3'd2, MREQ | PC2A | R2D | D2OPL, ALL, 2'd2, 2'd0, 1'b0);
        tick();

        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
